// File: rtl/aes_decipher_if.sv
// Handshake and data bus between the AES decipher block and its caller / key memory.
interface aes_decipher_if;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  modport master (
    output next, keylen, round_key, block,
    input  round, new_block, ready
  );

  modport slave (
    input  next, keylen, round_key, block,
    output round, new_block, ready
  );
endinterface

// File: rtl/aes_decipher_block.sv
// AES-128/256 inverse cipher: one round every five cycles, four of them spent
// pushing the state words one at a time through a single 32-bit inverse S-box.
module aes_decipher_block (
  input  logic          clk,
  input  logic          reset_n,
  aes_decipher_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_SBOX = 2'd2,
    ST_MAIN = 2'd3
  } state_t;

  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  state_t       state_r;
  logic [3:0]   round_ctr_r;
  logic [1:0]   sword_ctr_r;
  logic [127:0] block_r;
  logic         ready_r;

  logic [31:0]  sbox_in_s;
  logic [31:0]  sbox_out_s;
  logic [127:0] sbox_block_s;
  logic [127:0] add_key_s;

  // Table entry 0 sits in the top byte, so index down from the MSB.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return INV_SBOX_TABLE[idx -: 8];
  endfunction

  function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
    return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return (k[3] ? b8 : 8'h00) ^ (k[2] ? b4 : 8'h00) ^ (k[1] ? b2 : 8'h00) ^ (k[0] ? b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
            gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
            gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
            gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_column(s[127:96]), inv_mix_column(s[95:64]),
            inv_mix_column(s[63:32]), inv_mix_column(s[31:0])};
  endfunction

  // Row r of column c comes from column (c - r) mod 4; words are columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    return {s[127:120], s[23:16],   s[47:40],   s[71:64],
            s[95:88],   s[119:112], s[15:8],    s[39:32],
            s[63:56],   s[87:80],   s[111:104], s[7:0],
            s[31:24],   s[55:48],   s[79:72],   s[103:96]};
  endfunction

  // Route the selected state word through the shared S-box and splice it back.
  always_comb begin
    sbox_in_s    = 32'd0;
    sbox_block_s = block_r;
    add_key_s    = block_r ^ bus.round_key;
    case (sword_ctr_r)
      2'd0:    sbox_in_s = block_r[127:96];
      2'd1:    sbox_in_s = block_r[95:64];
      2'd2:    sbox_in_s = block_r[63:32];
      2'd3:    sbox_in_s = block_r[31:0];
      default: sbox_in_s = 32'd0;
    endcase
    sbox_out_s = inv_sub_word(sbox_in_s);
    case (sword_ctr_r)
      2'd0:    sbox_block_s[127:96] = sbox_out_s;
      2'd1:    sbox_block_s[95:64]  = sbox_out_s;
      2'd2:    sbox_block_s[63:32]  = sbox_out_s;
      2'd3:    sbox_block_s[31:0]   = sbox_out_s;
      default: sbox_block_s         = block_r;
    endcase
  end

  // Round sequencer and state register; keylen only matters at acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      round_ctr_r <= 4'd0;
      sword_ctr_r <= 2'd0;
      block_r     <= 128'd0;
      ready_r     <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.next) begin
            round_ctr_r <= bus.keylen ? 4'd14 : 4'd10;
            ready_r     <= 1'b0;
            state_r     <= ST_INIT;
          end
        end
        ST_INIT: begin
          block_r     <= inv_shift_rows(bus.block ^ bus.round_key);
          round_ctr_r <= round_ctr_r - 4'd1;
          sword_ctr_r <= 2'd0;
          state_r     <= ST_SBOX;
        end
        ST_SBOX: begin
          block_r     <= sbox_block_s;
          sword_ctr_r <= sword_ctr_r + 2'd1;
          if (sword_ctr_r == 2'd3) begin
            state_r <= ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (round_ctr_r != 4'd0) begin
            block_r     <= inv_shift_rows(inv_mix_columns(add_key_s));
            round_ctr_r <= round_ctr_r - 4'd1;
            sword_ctr_r <= 2'd0;
            state_r     <= ST_SBOX;
          end else begin
            block_r <= add_key_s;
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.round     = round_ctr_r;
  assign bus.new_block = block_r;
  assign bus.ready     = ready_r;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Directed-vector bench for aes_decipher_block; round keys come from a local key-expansion model.
module tb_aes_decipher_block;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  logic [127:0] rk_mem [16];

  aes_decipher_if bus ();

  aes_decipher_block dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.round_key = rk_mem[bus.round];

  always #5 clk = ~clk;

  localparam logic [127:0] PT_FIPS  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_256   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_SP    = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT_SP    = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [255:0] KEY_128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_SP   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [2047:0] tbl;
    logic [10:0]   idx;
    tbl = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    idx = 11'd2047 - {b, 3'b000};
    return tbl[idx -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic load_keys(input logic [255:0] key, input logic kl);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk;
    int total;
    nk    = kl ? 8 : 4;
    total = kl ? 60 : 44;
    rcon  = 8'h01;
    for (int i = 0; i < 64; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end else if (nk == 8 && i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Runs one operation; returns edges from acceptance to ready, and round-index mismatches.
  task automatic run_op(input logic [127:0] blk, input logic kl, input logic preloaded,
                        input int toggle_at, input int stop_at,
                        output int edges, output int round_errs, output logic [127:0] result);
    int nr;
    int exp_round;
    nr = kl ? 14 : 10;
    round_errs = 0;
    edges = 0;
    if (!preloaded) begin
      @(negedge clk);
      bus.block  = blk;
      bus.keylen = kl;
      bus.next   = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    bus.next = 1'b0;
    if (bus.round !== 4'(nr) || bus.ready !== 1'b0) round_errs++;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) bus.block = ~blk;
      bus.next = (edges == toggle_at);
      if (edges == toggle_at) bus.keylen = ~bus.keylen;
      exp_round = (edges <= 5*nr) ? nr - 1 - (edges - 1) / 5 : 0;
      if (bus.round !== 4'(exp_round)) round_errs++;
      if (bus.ready === 1'b1 || edges == stop_at) break;
    end
    result = bus.new_block;
  endtask

  task automatic test_reset();
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
    tests_run++;
    if (bus.new_block !== 128'h0) begin tests_failed++; $display("FAIL reset_new_block: got %h expected 0", bus.new_block); end
    tests_run++;
    if (bus.round !== 4'd0) begin tests_failed++; $display("FAIL reset_round: got %0d expected 0", bus.round); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_aes128();
    int edges, rerr;
    logic [127:0] res;
    load_keys(KEY_128, 1'b0);
    run_op(CT_128, 1'b0, 1'b0, 0, 0, edges, rerr, res);
    tests_run++;
    if (edges !== 51) begin tests_failed++; $display("FAIL aes128_latency: got %0d expected 51", edges); end
    tests_run++;
    if (res !== PT_FIPS) begin tests_failed++; $display("FAIL aes128_result: got %h expected %h", res, PT_FIPS); end
    tests_run++;
    if (rerr !== 0) begin tests_failed++; $display("FAIL aes128_round_seq: got %0d bad cycles expected 0", rerr); end
  endtask

  task automatic test_aes256();
    int edges, rerr;
    logic [127:0] res;
    load_keys(KEY_256, 1'b1);
    run_op(CT_256, 1'b1, 1'b0, 0, 0, edges, rerr, res);
    tests_run++;
    if (edges !== 71) begin tests_failed++; $display("FAIL aes256_latency: got %0d expected 71", edges); end
    tests_run++;
    if (res !== PT_FIPS) begin tests_failed++; $display("FAIL aes256_result: got %h expected %h", res, PT_FIPS); end
    tests_run++;
    if (rerr !== 0) begin tests_failed++; $display("FAIL aes256_round_seq: got %0d bad cycles expected 0", rerr); end
    repeat (4) @(negedge clk);
    tests_run++;
    if (bus.ready !== 1'b1 || bus.new_block !== PT_FIPS) begin
      tests_failed++;
      $display("FAIL idle_hold: got ready=%b block=%h expected ready=1 block=%h", bus.ready, bus.new_block, PT_FIPS);
    end
  endtask

  task automatic test_busy();
    int edges, rerr;
    logic [127:0] res;
    load_keys(KEY_SP, 1'b0);
    run_op(CT_SP, 1'b0, 1'b0, 20, 0, edges, rerr, res);
    tests_run++;
    if (edges !== 51) begin tests_failed++; $display("FAIL busy_latency: got %0d expected 51", edges); end
    tests_run++;
    if (res !== PT_SP) begin tests_failed++; $display("FAIL busy_result: got %h expected %h", res, PT_SP); end
  endtask

  task automatic test_abort();
    int edges, rerr;
    logic [127:0] res;
    load_keys(KEY_128, 1'b0);
    run_op(CT_128, 1'b0, 1'b0, 0, 30, edges, rerr, res);
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.ready !== 1'b1 || bus.new_block !== 128'h0 || bus.round !== 4'd0) begin
      tests_failed++;
      $display("FAIL abort_reset: got ready=%b block=%h round=%0d expected 1/0/0", bus.ready, bus.new_block, bus.round);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_op(CT_128, 1'b0, 1'b0, 0, 0, edges, rerr, res);
    tests_run++;
    if (edges !== 51) begin tests_failed++; $display("FAIL abort_rerun_latency: got %0d expected 51", edges); end
    tests_run++;
    if (res !== PT_FIPS) begin tests_failed++; $display("FAIL abort_rerun_result: got %h expected %h", res, PT_FIPS); end
  endtask

  task automatic test_back_to_back();
    int edges1, edges2, rerr1, rerr2;
    logic [127:0] res1, res2;
    load_keys(KEY_128, 1'b0);
    run_op(CT_128, 1'b0, 1'b0, 0, 0, edges1, rerr1, res1);
    load_keys(KEY_SP, 1'b0);
    bus.block  = CT_SP;
    bus.keylen = 1'b0;
    bus.next   = 1'b1;
    run_op(CT_SP, 1'b0, 1'b1, 0, 0, edges2, rerr2, res2);
    tests_run++;
    if (res1 !== PT_FIPS) begin tests_failed++; $display("FAIL b2b_first_result: got %h expected %h", res1, PT_FIPS); end
    tests_run++;
    if (res2 !== PT_SP) begin tests_failed++; $display("FAIL b2b_second_result: got %h expected %h", res2, PT_SP); end
    tests_run++;
    if (edges1 + 1 + edges2 !== 103) begin
      tests_failed++;
      $display("FAIL b2b_total_edges: got %0d expected 103", edges1 + 1 + edges2);
    end
    tests_run++;
    if (rerr2 !== 0) begin tests_failed++; $display("FAIL b2b_round_seq: got %0d bad cycles expected 0", rerr2); end
  endtask

  initial begin
    clk          = 1'b0;
    reset_n      = 1'b1;
    tests_run    = 0;
    tests_failed = 0;
    bus.next     = 1'b0;
    bus.keylen   = 1'b0;
    bus.block    = 128'h0;
    for (int r = 0; r < 16; r++) rk_mem[r] = 128'h0;
    test_reset();
    test_aes128();
    test_aes256();
    test_busy();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
